// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin sequencer in front of a single-port memory.
// Port 0 is instruction fetch, port 1 is load/store. One access is in flight at a
// time: IDLE arbitrates and latches the winner, ACCESS drives one memory strobe,
// WAIT counts out the read latency and returns the read data to the winner.
// Every output comes straight from a flop.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_wn,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_read_data
);

   // Counter reload value; the latency is limited to 1..15 so four bits suffice.
   localparam logic [3:0] RD_LAT = 4'(MEM_RD_LAT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2
   } state_t;

   state_t              state_r, state_s;
   logic                last_r, last_s;     // port served most recently
   logic                port_r, port_s;     // port owning the current transaction
   logic                we_r, we_s;
   logic [ADDR_W-1:0]   addr_r, addr_s;
   logic [DATA_W-1:0]   wdata_r, wdata_s;
   logic [3:0]          cnt_r, cnt_s;
   logic                win_s;

   logic                m0_gnt_s, m1_gnt_s;
   logic                m0_rvalid_s, m1_rvalid_s;
   logic [DATA_W-1:0]   m0_rdata_s, m1_rdata_s;
   logic                busy_s;
   logic [ADDR_W-1:0]   mem_address_s;
   logic [DATA_W-1:0]   mem_write_data_s;
   logic                mem_wn_s, mem_rd_s;

   // Next-state logic and next values for every registered output.
   always_comb begin
      state_s          = state_r;
      last_s           = last_r;
      port_s           = port_r;
      we_s             = we_r;
      addr_s           = addr_r;
      wdata_s          = wdata_r;
      cnt_s            = cnt_r;
      win_s            = 1'b0;
      m0_gnt_s         = 1'b0;
      m1_gnt_s         = 1'b0;
      m0_rvalid_s      = 1'b0;
      m1_rvalid_s      = 1'b0;
      m0_rdata_s       = m0_rdata;
      m1_rdata_s       = m1_rdata;
      mem_address_s    = mem_address;
      mem_write_data_s = mem_write_data;
      mem_wn_s         = 1'b0;
      mem_rd_s         = 1'b0;

      case (state_r)
         IDLE: begin
            // On a tie the port not served last wins; otherwise the lone requester.
            if (m0_req && m1_req) begin
               win_s = ~last_r;
            end else begin
               win_s = m1_req;
            end
            if (m0_req || m1_req) begin
               port_s   = win_s;
               last_s   = win_s;
               we_s     = win_s ? m1_we    : m0_we;
               addr_s   = win_s ? m1_addr  : m0_addr;
               wdata_s  = win_s ? m1_wdata : m0_wdata;
               m0_gnt_s = ~win_s;
               m1_gnt_s = win_s;
               state_s  = ACCESS;
            end else begin
               state_s  = IDLE;
            end
         end
         ACCESS: begin
            mem_address_s = addr_r;
            if (we_r) begin
               mem_wn_s         = 1'b1;
               mem_write_data_s = wdata_r;
               state_s          = IDLE;
            end else begin
               mem_rd_s = 1'b1;
               cnt_s    = RD_LAT;
               state_s  = WAIT;
            end
         end
         WAIT: begin
            // The last counted cycle is the one in which read data is valid.
            if (cnt_r <= 4'd1) begin
               if (port_r) begin
                  m1_rdata_s  = mem_read_data;
                  m1_rvalid_s = 1'b1;
               end else begin
                  m0_rdata_s  = mem_read_data;
                  m0_rvalid_s = 1'b1;
               end
               state_s = IDLE;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      busy_s = (state_s != IDLE);
   end

   // FSM state and the latched transaction; reset drops any in-flight access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         last_r  <= 1'b1;
         port_r  <= 1'b0;
         we_r    <= 1'b0;
         addr_r  <= '0;
         wdata_r <= '0;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_s;
         last_r  <= last_s;
         port_r  <= port_s;
         we_r    <= we_s;
         addr_r  <= addr_s;
         wdata_r <= wdata_s;
         cnt_r   <= cnt_s;
      end
   end

   // Output registers: requester handshakes, read data and memory strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_gnt         <= 1'b0;
         m1_gnt         <= 1'b0;
         m0_rvalid      <= 1'b0;
         m1_rvalid      <= 1'b0;
         m0_rdata       <= '0;
         m1_rdata       <= '0;
         busy           <= 1'b0;
         mem_address    <= '0;
         mem_write_data <= '0;
         mem_wn         <= 1'b0;
         mem_rd         <= 1'b0;
      end else begin
         m0_gnt         <= m0_gnt_s;
         m1_gnt         <= m1_gnt_s;
         m0_rvalid      <= m0_rvalid_s;
         m1_rvalid      <= m1_rvalid_s;
         m0_rdata       <= m0_rdata_s;
         m1_rdata       <= m1_rdata_s;
         busy           <= busy_s;
         mem_address    <= mem_address_s;
         mem_write_data <= mem_write_data_s;
         mem_wn         <= mem_wn_s;
         mem_rd         <= mem_rd_s;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (read latency 1 and 3), each with a simple
// memory model. Directed table of single-port transactions, hand sequences for
// arbitration, reset and glitch corners, then random traffic against a cycle
// schedule derived from the arbitration and latency rules.
module tb_mem_arbiter;

   localparam int NR = 1500;
   localparam int NE = NR + 40;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [2];
   logic        req0 [2], req1 [2], we0 [2], we1 [2];
   logic [31:0] addr0 [2], addr1 [2], wd0 [2], wd1 [2];
   logic        gnt0 [2], gnt1 [2], rv0 [2], rv1 [2], busy [2], wn [2], rd [2];
   logic [31:0] rdata0 [2], rdata1 [2], maddr [2], mwd [2], mrd [2];
   logic [31:0] memarr [2][256];
   logic        mem_clr;

   int n_cmp, n_bad;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_RD_LAT(1)) dut_a (
      .clk(clk), .rst_n(rst_n[0]),
      .m0_req(req0[0]), .m0_we(we0[0]), .m0_addr(addr0[0]), .m0_wdata(wd0[0]),
      .m1_req(req1[0]), .m1_we(we1[0]), .m1_addr(addr1[0]), .m1_wdata(wd1[0]),
      .m0_gnt(gnt0[0]), .m0_rvalid(rv0[0]), .m0_rdata(rdata0[0]),
      .m1_gnt(gnt1[0]), .m1_rvalid(rv1[0]), .m1_rdata(rdata1[0]),
      .busy(busy[0]), .mem_address(maddr[0]), .mem_write_data(mwd[0]),
      .mem_wn(wn[0]), .mem_rd(rd[0]), .mem_read_data(mrd[0]));

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_RD_LAT(3)) dut_b (
      .clk(clk), .rst_n(rst_n[1]),
      .m0_req(req0[1]), .m0_we(we0[1]), .m0_addr(addr0[1]), .m0_wdata(wd0[1]),
      .m1_req(req1[1]), .m1_we(we1[1]), .m1_addr(addr1[1]), .m1_wdata(wd1[1]),
      .m0_gnt(gnt0[1]), .m0_rvalid(rv0[1]), .m0_rdata(rdata0[1]),
      .m1_gnt(gnt1[1]), .m1_rvalid(rv1[1]), .m1_rdata(rdata1[1]),
      .busy(busy[1]), .mem_address(maddr[1]), .mem_write_data(mwd[1]),
      .mem_wn(wn[1]), .mem_rd(rd[1]), .mem_read_data(mrd[1]));

   // Memory block: writes on the edge that sees wn, read data follows the address.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (mem_clr) begin
            for (int i = 0; i < 256; i++) memarr[d][i] <= 32'h0;
         end else if (wn[d]) begin
            memarr[d][maddr[d][7:0]] <= mwd[d];
         end
      end
   end
   assign mrd[0] = memarr[0][maddr[0][7:0]];
   assign mrd[1] = memarr[1][maddr[1][7:0]];

   function automatic int lat(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_port(input int d, input int p, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] dat);
      if (p == 0) begin
         req0[d] = r; we0[d] = w; addr0[d] = a; wd0[d] = dat;
      end else begin
         req1[d] = r; we1[d] = w; addr1[d] = a; wd1[d] = dat;
      end
   endtask

   task automatic drop_req(input int d, input int p);
      if (p == 0) req0[d] = 1'b0;
      else        req1[d] = 1'b0;
   endtask

   task automatic chk_all_zero(input int d, input string nm);
      chk({nm, " gnt0"}, gnt0[d], 0);    chk({nm, " gnt1"}, gnt1[d], 0);
      chk({nm, " rv0"}, rv0[d], 0);      chk({nm, " rv1"}, rv1[d], 0);
      chk({nm, " rdata0"}, rdata0[d], 0); chk({nm, " rdata1"}, rdata1[d], 0);
      chk({nm, " busy"}, busy[d], 0);    chk({nm, " maddr"}, maddr[d], 0);
      chk({nm, " mwd"}, mwd[d], 0);      chk({nm, " wn"}, wn[d], 0);
      chk({nm, " rd"}, rd[d], 0);
   endtask

   // One single-port transaction, started just after a falling edge with the arbiter idle.
   task automatic do_txn(input int d, input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] dat, input logic [31:0] er, input string nm);
      logic got;
      set_port(d, p, 1'b1, w, a, dat);
      @(posedge clk); @(negedge clk);
      chk({nm, " gnt"}, (p == 0) ? gnt0[d] : gnt1[d], 1);
      chk({nm, " other gnt"}, (p == 0) ? gnt1[d] : gnt0[d], 0);
      chk({nm, " busy"}, busy[d], 1);
      chk({nm, " no early strobe"}, {wn[d], rd[d]}, 0);
      drop_req(d, p);
      @(negedge clk);
      chk({nm, " gnt gone"}, {gnt0[d], gnt1[d]}, 0);
      chk({nm, " wn"}, wn[d], w);
      chk({nm, " rd"}, rd[d], !w);
      chk({nm, " maddr"}, maddr[d], a);
      if (w) begin
         chk({nm, " mwd"}, mwd[d], dat);
         @(negedge clk);
         chk({nm, " wn one cycle"}, wn[d], 0);
         chk({nm, " idle"}, busy[d], 0);
      end else begin
         got = 1'b0;
         for (int j = 2; j <= 20 && !got; j++) begin
            @(negedge clk);
            if (j == 2) chk({nm, " rd one cycle"}, rd[d], 0);
            chk({nm, " other rvalid"}, (p == 0) ? rv1[d] : rv0[d], 0);
            if (((p == 0) ? rv0[d] : rv1[d]) === 1'b1) begin
               got = 1'b1;
               chk({nm, " rvalid edge"}, j, 1 + lat(d));
               chk({nm, " rdata"}, (p == 0) ? rdata0[d] : rdata1[d], er);
            end
         end
         chk({nm, " rvalid seen"}, got, 1);
         @(negedge clk);
         chk({nm, " rvalid pulse"}, {rv0[d], rv1[d]}, 0);
         chk({nm, " idle"}, busy[d], 0);
      end
   endtask

   typedef struct {
      int          d;
      int          p;
      logic        we;
      logic [31:0] a;
      logic [31:0] w;
      logic [31:0] er;
   } vec_t;

   // Reference model state for random traffic.
   bit          eg [2][2][NE];
   bit          erv [2][2][NE];
   bit          ewn [2][NE];
   bit          erd [2][NE];
   bit          ebusy [2][NE];
   logic [31:0] eaddr [2][NE];
   logic [31:0] ewd [2][NE];
   logic [31:0] erdv [2][2][NE];
   logic [31:0] refmem [2][256];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        tbl [11];
      int          gq [$];
      int          n_tie;
      int          frees [2];
      int          served_last [2];
      bit          gflag [2][2];
      logic [31:0] haddr [2], hwd [2], hrd [2][2];

      n_cmp = 0; n_bad = 0; mem_clr = 1'b1;
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0;
         set_port(d, 0, 1'b0, 1'b0, 32'h0, 32'h0);
         set_port(d, 1, 1'b0, 1'b0, 32'h0, 32'h0);
         for (int i = 0; i < 256; i++) refmem[d][i] = 32'h0;
      end

      tbl[0]  = '{0, 0, 1'b1, 32'h1, 32'h1,  32'h0};
      tbl[1]  = '{0, 1, 1'b1, 32'h2, 32'h10, 32'h0};
      tbl[2]  = '{0, 1, 1'b0, 32'h2, 32'h0,  32'h10};
      tbl[3]  = '{0, 0, 1'b0, 32'h1, 32'h0,  32'h1};
      tbl[4]  = '{0, 0, 1'b1, 32'h2, 32'hAB, 32'h0};
      tbl[5]  = '{0, 1, 1'b0, 32'h2, 32'h0,  32'hAB};
      tbl[6]  = '{0, 0, 1'b0, 32'h7, 32'h0,  32'h0};
      tbl[7]  = '{1, 0, 1'b1, 32'h3, 32'h6,  32'h0};
      tbl[8]  = '{1, 1, 1'b0, 32'h3, 32'h0,  32'h6};
      tbl[9]  = '{1, 0, 1'b1, 32'h3, 32'h7,  32'h0};
      tbl[10] = '{1, 0, 1'b0, 32'h3, 32'h0,  32'h7};

      repeat (2) @(negedge clk);
      mem_clr = 1'b0;
      for (int d = 0; d < 2; d++) chk_all_zero(d, "reset");
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      @(negedge clk);

      // Directed single-port table.
      for (int i = 0; i < 11; i++) begin
         do_txn(tbl[i].d, tbl[i].p, tbl[i].we, tbl[i].a, tbl[i].w, tbl[i].er,
                $sformatf("vec%0d", i));
      end
      chk("m1 rdata kept after write", rdata1[1], 32'h6);
      chk("m1 rdata kept after m0 read", rdata1[0], 32'hAB);

      // Asynchronous reset in the middle of a latency-3 read.
      set_port(1, 0, 1'b1, 1'b0, 32'h3, 32'h0);
      @(posedge clk); @(negedge clk);
      drop_req(1, 0);
      @(negedge clk);
      chk("pre-reset rd", rd[1], 1);
      @(negedge clk);
      #2 rst_n[1] = 1'b0;
      #1 chk_all_zero(1, "async reset");
      @(negedge clk);
      rst_n[1] = 1'b1;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         chk("post-reset quiet", {rv0[1], rv1[1], wn[1], rd[1], busy[1]}, 0);
      end

      // Both ports request continuously: grants must alternate starting with m0.
      set_port(1, 0, 1'b1, 1'b1, 32'h10, 32'hA0);
      set_port(1, 1, 1'b1, 1'b1, 32'h11, 32'hB1);
      for (int j = 0; j < 40 && gq.size() < 4; j++) begin
         @(negedge clk);
         chk("tie single gnt", gnt0[1] & gnt1[1], 0);
         if (gnt0[1] === 1'b1) gq.push_back(0);
         if (gnt1[1] === 1'b1) gq.push_back(1);
      end
      drop_req(1, 0); drop_req(1, 1);
      chk("tie grant count", gq.size(), 4);
      n_tie = gq.size();
      for (int i = 0; i < n_tie; i++) chk($sformatf("tie order %0d", i), gq[i], i % 2);
      repeat (3) @(negedge clk);
      chk("tie m1 write landed", memarr[1][17], 32'hB1);

      // m1 request glitches low before it can be granted during an m0 read.
      set_port(0, 0, 1'b1, 1'b0, 32'h1, 32'h0);
      @(posedge clk); @(negedge clk);
      drop_req(0, 0);
      set_port(0, 1, 1'b1, 1'b1, 32'h1F, 32'hDEAD);
      @(negedge clk);
      drop_req(0, 1);
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         chk("glitch no m1 gnt", gnt1[0], 0);
         chk("glitch strobe excl", wn[0] & rd[0], 0);
      end
      chk("glitch no m1 write", memarr[0][31], 32'h0);
      chk("glitch m0 rdata", rdata0[0], 32'h1);

      // Random traffic on both instances from a fresh reset.
      rst_n[0] = 1'b0; rst_n[1] = 1'b0;
      @(negedge clk);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      for (int d = 0; d < 2; d++) begin
         frees[d] = 0; served_last[d] = 1;
         haddr[d] = 32'h0; hwd[d] = 32'h0; hrd[d][0] = 32'h0; hrd[d][1] = 32'h0;
      end
      for (int k = 0; k < NR; k++) begin
         @(posedge clk);
         for (int d = 0; d < 2; d++) begin
            logic r0, r1, tw;
            logic [31:0] ta, tdat;
            int win, f;
            gflag[d][0] = 1'b0; gflag[d][1] = 1'b0;
            r0 = req0[d]; r1 = req1[d];
            if (k >= frees[d] && (r0 || r1)) begin
               if (r0 && r1) win = 1 - served_last[d];
               else          win = r1 ? 1 : 0;
               served_last[d] = win;
               gflag[d][win] = 1'b1;
               tw   = (win == 0) ? we0[d] : we1[d];
               ta   = (win == 0) ? addr0[d] : addr1[d];
               tdat = (win == 0) ? wd0[d] : wd1[d];
               f = tw ? k + 2 : k + 2 + lat(d);
               eg[d][win][k] = 1'b1;
               for (int i = k; i < f - 1; i++) ebusy[d][i] = 1'b1;
               eaddr[d][k + 1] = ta;
               if (tw) begin
                  ewn[d][k + 1] = 1'b1;
                  ewd[d][k + 1] = tdat;
                  refmem[d][ta[7:0]] = tdat;
               end else begin
                  erd[d][k + 1] = 1'b1;
                  erv[d][win][k + 1 + lat(d)] = 1'b1;
                  erdv[d][win][k + 1 + lat(d)] = refmem[d][ta[7:0]];
               end
               frees[d] = f;
            end
         end
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (ewn[d][k] || erd[d][k]) haddr[d] = eaddr[d][k];
            if (ewn[d][k]) hwd[d] = ewd[d][k];
            for (int p = 0; p < 2; p++) if (erv[d][p][k]) hrd[d][p] = erdv[d][p][k];
            chk($sformatf("rnd%0d gnt0", d), gnt0[d], eg[d][0][k]);
            chk($sformatf("rnd%0d gnt1", d), gnt1[d], eg[d][1][k]);
            chk($sformatf("rnd%0d rv0", d), rv0[d], erv[d][0][k]);
            chk($sformatf("rnd%0d rv1", d), rv1[d], erv[d][1][k]);
            chk($sformatf("rnd%0d rdata0", d), rdata0[d], hrd[d][0]);
            chk($sformatf("rnd%0d rdata1", d), rdata1[d], hrd[d][1]);
            chk($sformatf("rnd%0d busy", d), busy[d], ebusy[d][k]);
            chk($sformatf("rnd%0d wn", d), wn[d], ewn[d][k]);
            chk($sformatf("rnd%0d rd", d), rd[d], erd[d][k]);
            chk($sformatf("rnd%0d maddr", d), maddr[d], haddr[d]);
            chk($sformatf("rnd%0d mwd", d), mwd[d], hwd[d]);
            // Next requester behaviour.
            for (int p = 0; p < 2; p++) begin
               logic cur;
               cur = (p == 0) ? req0[d] : req1[d];
               if (gflag[d][p]) begin
                  if ($urandom % 2 == 0)
                     set_port(d, p, 1'b1, 1'($urandom % 2), 32'h40 + ($urandom % 16), $urandom);
                  else
                     drop_req(d, p);
               end else if (cur) begin
                  if ($urandom % 16 == 0) drop_req(d, p);
               end else if ($urandom % 3 == 0) begin
                  set_port(d, p, 1'b1, 1'($urandom % 2), 32'h40 + ($urandom % 16), $urandom);
               end
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
